// File: rtl/bitty_control_unit.sv
// Multi-cycle control sequencer for the bitty core: decodes the fetched word and
// drives datapath enables, the PC strobe and the completion pulse.
module bitty_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic [15:0] alu_result,
  output logic [3:0]  mux_sel,
  output logic        en_s,
  output logic        en_c,
  output logic [7:0]  en_i,
  output logic [2:0]  alu_sel,
  output logic [15:0] imm_out,
  output logic        en_pc,
  output logic        done,
  output logic [15:0] last_alu_result
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StLoadS,
    StLoadC,
    StWb,
    StBranch
  } state_e;

  localparam logic [3:0] MuxImm = 4'd8;
  localparam logic [3:0] MuxC   = 4'd9;

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] last_q;

  logic [1:0] fmt;
  logic [2:0] rx;
  logic [2:0] ry;

  assign fmt             = ir_q[1:0];
  assign rx              = ir_q[15:13];
  assign ry              = ir_q[12:10];
  assign alu_sel         = ir_q[4:2];
  assign imm_out         = {8'h00, ir_q[12:5]};
  assign last_alu_result = last_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ir_q    <= 16'h0000;
      last_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) ir_q <= instruction;
      if (state_q == StWb) last_q <= alu_result;
    end
  end

  always_comb begin
    state_d = state_q;
    mux_sel = 4'd0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    en_i    = 8'h00;
    en_pc   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        // ir is being loaded this cycle, so branch on the incoming word
        state_d = instruction[1] ? StBranch : StLoadS;
      end
      StLoadS: begin
        mux_sel = {1'b0, rx};
        en_s    = 1'b1;
        state_d = StLoadC;
      end
      StLoadC: begin
        mux_sel = (fmt == 2'b01) ? MuxImm : {1'b0, ry};
        en_c    = 1'b1;
        state_d = StWb;
      end
      StWb: begin
        mux_sel  = MuxC;
        en_i[rx] = 1'b1;
        en_pc    = 1'b1;
        done     = 1'b1;
        state_d  = run ? StFetch : StIdle;
      end
      StBranch: begin
        en_pc   = 1'b1;
        done    = 1'b1;
        state_d = run ? StFetch : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_bitty_control_unit.sv
// Randomized self-checking bench for bitty_control_unit against an instruction-level
// model of the expected per-cycle control outputs.
module tb_bitty_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic [15:0] alu_result;
  logic [3:0]  mux_sel;
  logic        en_s;
  logic        en_c;
  logic [7:0]  en_i;
  logic [2:0]  alu_sel;
  logic [15:0] imm_out;
  logic        en_pc;
  logic        done;
  logic [15:0] last_alu_result;

  int total = 0;
  int bad   = 0;
  logic [15:0] model_last = 16'h0000;

  bitty_control_unit dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .instruction     (instruction),
    .alu_result      (alu_result),
    .mux_sel         (mux_sel),
    .en_s            (en_s),
    .en_c            (en_c),
    .en_i            (en_i),
    .alu_sel         (alu_sel),
    .imm_out         (imm_out),
    .en_pc           (en_pc),
    .done            (done),
    .last_alu_result (last_alu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // strobes packed as {en_s, en_c, en_pc, done}
  task automatic expect_cycle(input string tag, input logic [3:0] mux, input logic [3:0] strb,
                              input logic [7:0] ei);
    chk({tag, ".mux"}, {28'h0, mux_sel}, {28'h0, mux});
    chk({tag, ".strb"}, {28'h0, en_s, en_c, en_pc, done}, {28'h0, strb});
    chk({tag, ".en_i"}, {24'h0, en_i}, {24'h0, ei});
    chk({tag, ".last"}, {16'h0, last_alu_result}, {16'h0, model_last});
  endtask

  // Entry: at a falling edge with the DUT in FETCH. Exit: same, or resumes from IDLE.
  task automatic do_instr(input logic [15:0] w, input logic [15:0] a, input bit keep_run);
    logic [1:0] f;
    logic [2:0] rx, ry;
    f  = w[1:0];
    rx = w[15:13];
    ry = w[12:10];
    instruction = w;
    alu_result  = a;
    expect_cycle("fetch", 4'd0, 4'b0000, 8'h00);
    @(negedge clk);
    expect_cycle("decode", 4'd0, 4'b0000, 8'h00);
    if (f[1] == 1'b0) begin
      @(negedge clk);
      expect_cycle("load_s", {1'b0, rx}, 4'b1000, 8'h00);
      if (!keep_run) run = 1'b0;
      @(negedge clk);
      expect_cycle("load_c", (f == 2'b01) ? 4'd8 : {1'b0, ry}, 4'b0100, 8'h00);
      chk("load_c.alu_sel", {29'h0, alu_sel}, {29'h0, w[4:2]});
      chk("load_c.imm", {16'h0, imm_out}, {24'h0, w[12:5]});
      @(negedge clk);
      expect_cycle("wb", 4'd9, 4'b0011, 8'h01 << rx);
      model_last = a;
    end else begin
      if (!keep_run) run = 1'b0;
      @(negedge clk);
      expect_cycle("branch", 4'd0, 4'b0011, 8'h00);
    end
    @(negedge clk);
    if (!keep_run) begin
      int idle_cycles;
      idle_cycles = $urandom_range(1, 3);
      for (int i = 0; i < idle_cycles; i++) begin
        expect_cycle("idle", 4'd0, 4'b0000, 8'h00);
        @(negedge clk);
      end
      expect_cycle("idle", 4'd0, 4'b0000, 8'h00);
      run = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    reset       = 1'b0;
    run         = 1'b0;
    instruction = 16'h0000;
    alu_result  = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_cycle("reset", 4'd0, 4'b0000, 8'h00);
    chk("reset.alu_sel", {29'h0, alu_sel}, 32'h0);
    chk("reset.imm", {16'h0, imm_out}, 32'h0);
    run = 1'b1;
    @(negedge clk);

    do_instr(16'h2400, 16'h0006, 1'b1);
    chk("rtype.last", {16'h0, last_alu_result}, 32'h6);
    do_instr(16'hE0A5, 16'h1234, 1'b1);
    do_instr(16'h0032, 16'hBEEF, 1'b1);
    chk("branch.last", {16'h0, last_alu_result}, 32'h1234);
    do_instr(16'hFFFF, 16'hAAAA, 1'b1);
    do_instr(16'h4C01, 16'h00F0, 1'b0);
    do_instr(16'h0032, 16'h5555, 1'b0);

    for (int n = 0; n < 60; n++) begin
      do_instr(16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    // reset asserted while in LOAD_C
    do_instr(16'h6209, 16'h7777, 1'b1);
    instruction = 16'h2400;
    alu_result  = 16'h0042;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.en_c", {31'h0, en_c}, 32'h1);
    reset = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    model_last = 16'h0000;
    expect_cycle("rst_mid", 4'd0, 4'b0000, 8'h00);
    chk("rst_mid.alu_sel", {29'h0, alu_sel}, 32'h0);
    chk("rst_mid.imm", {16'h0, imm_out}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    expect_cycle("rst_idle", 4'd0, 4'b0000, 8'h00);
    run = 1'b1;
    @(negedge clk);
    do_instr(16'hA801, 16'h0099, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitty_control_unit.md
# bitty_control_unit

Multi-cycle control sequencer for the bitty core. It sits directly downstream of the fetch stage: it consumes the 16-bit word from the instruction memory and decodes it. It then drives the register-file and ALU enables of the external datapath, and closes each instruction by pulsing `en_pc` and `done`. It also owns `last_alu_result`, the value the branch logic compares against when it computes the next PC.

## Interface

No parameters.

Ports:

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising edge of `clk`; `reset`=0 forces the reset state.
- `run` in 1: execution enable; sampled only at instruction boundaries.
- `instruction` in 16: memory read data; valid the cycle after FETCH because the memory has a registered output.
- `alu_result` in 16: contents of the datapath C register.
- `mux_sel` out 4: bus source select. 0–7 selects R0–R7, 8 selects the immediate, 9 selects C.
- `en_s` out 1: load the S register from the bus.
- `en_c` out 1: load the C register with the ALU output.
- `en_i` out 8: one-hot register-file write enable.
- `alu_sel` out 3: ALU operation.
- `imm_out` out 16: zero-extended immediate.
- `en_pc` out 1: PC update strobe.
- `done` out 1: instruction-complete pulse.
- `last_alu_result` out 16: most recent written-back ALU result.

## Operation

- Instruction register `ir` (16 bits):
  - Latched from `instruction` in DECODE.
  - Every decode field derives from `ir`, never from `instruction` directly.
- Fields:
  - `fmt` = ir[1:0]
  - `rx` = ir[15:13]
  - `ry` = ir[12:10]
  - `alu_sel` = ir[4:2]
  - `imm8` = ir[12:5]
  - `imm_out` = {8'h00, imm8}; it is driven continuously from `ir`.
- Formats:
  - 00 is R-type: Rx ← Rx op Ry.
  - 01 is I-type: Rx ← Rx op imm8.
  - 10 is branch: no datapath action.
  - 11 is reserved and executes as a NOP.
- States are IDLE, FETCH, DECODE, LOAD_S, LOAD_C, WB and BRANCH.
- IDLE:
  - All strobes are 0.
  - Goes to FETCH when `run`=1, otherwise stays in IDLE.
- FETCH:
  - The PC is stable and memory is reading.
  - Always goes to DECODE.
- DECODE:
  - `ir` ← `instruction`.
  - The next state is chosen from `instruction[1:0]`, the incoming word: 00 or 01 go to LOAD_S; 10 or 11 go to BRANCH.
- LOAD_S:
  - `mux_sel`=`rx`, `en_s`=1.
  - Goes to LOAD_C.
- LOAD_C:
  - `mux_sel`=`ry` for R-type, or 8 for I-type.
  - `alu_sel` is driven and `en_c`=1.
  - Goes to WB.
- WB:
  - `mux_sel`=9 and `en_i`[`rx`]=1.
  - `last_alu_result` ← `alu_result`.
  - `done`=1, `en_pc`=1.
- BRANCH:
  - `done`=1 and `en_pc`=1.
  - `last_alu_result` is unchanged.
- Exit from WB or BRANCH: go to FETCH if `run`=1, otherwise IDLE.
- Outputs are decoded from the current state and `ir` (Moore style).
  - Outside the states listed above, `mux_sel`=0, `en_s`/`en_c`/`en_pc`/`done`=0 and `en_i`=0.
  - `alu_sel` is only meaningful in LOAD_C.
- `en_i` is always zero or one-hot. A write to R0 is permitted.
- `rx`==`ry` is legal; no special handling.
- A `run` deassertion in the middle of an instruction does not abort it; the instruction completes and the block then enters IDLE.

## Timing

- Reset (`reset`=0 at a rising edge) applies the following on the next cycle, regardless of the current state:
  - state = IDLE
  - `ir`=16'h0000
  - `last_alu_result`=16'h0000
  - every strobe 0, `mux_sel`=0, `en_i`=0
  - consequently `alu_sel`=0 and `imm_out`=16'h0000
- Instruction latency, counted from entering FETCH:
  - R-type and I-type: 5 cycles (FETCH, DECODE, LOAD_S, LOAD_C, WB).
  - Branch and NOP: 3 cycles (FETCH, DECODE, BRANCH).
- `done` and `en_pc` are asserted for exactly one cycle per instruction.
- Back-to-back execution with `run` held at 1: the cycle after WB or BRANCH is FETCH; there is no bubble.
- `last_alu_result` changes only on the clock edge that ends WB, so a following branch sees it by that branch's BRANCH cycle.
- The PC updates on the edge that ends WB or BRANCH. The memory output therefore reflects the new PC at the end of the next FETCH.
- `run` is sampled in IDLE, WB and BRANCH only.

## Test plan

- **Reset mid-operation.** Hold `reset`=0 for one edge while in LOAD_C → next cycle state=IDLE, all strobes 0, `last_alu_result`=0, `ir`=0.
- **R-type.** `run`=1, `instruction`=16'h2400 (Rx=1, Ry=1, op 0, fmt 00), `alu_result`=16'h0006 → required responses:
  - LOAD_S: `mux_sel`=1, `en_s`=1.
  - LOAD_C: `mux_sel`=1, `en_c`=1, `alu_sel`=0.
  - WB: `mux_sel`=9, `en_i`=8'h02, `done`=1.
  - Then `last_alu_result`=6.
  - Total 5 cycles.
- **I-type.** `instruction`=16'hE0A5 (Rx=7, imm8=5, op 1, fmt 01) → required responses:
  - `imm_out`=16'h0005.
  - LOAD_C: `mux_sel`=8, `alu_sel`=1.
  - WB: `en_i`=8'h80.
- **Branch.** `instruction`=16'h0032 (fmt 10) → required responses:
  - `done` and `en_pc` high in cycle 3.
  - No `en_s`, `en_c` or `en_i` activity.
  - `last_alu_result` unchanged.
- **Run drop.** Deassert `run` during LOAD_S → the instruction completes through WB, the block then enters IDLE with no further FETCH, and re-asserting `run` resumes with FETCH on the next cycle.
- **Reserved format.** `instruction`=16'hFFFF (fmt 11) → executes as a NOP with 3-cycle latency and no writes.
